gemm2x2_k_sequencer: RTL and testbench

Control block that computes one 2x2 output tile of C = A·B over an arbitrary K dimension by driving `mac_array_2x2` one K-slice at a time. It accepts K-slices from an operand stream, issues each to the MAC array with the running partial sums as accumulator inputs, and captures results on `out_valid`. It returns the finished tile through a valid/ready result port. It sits between the operand fetch logic and the MAC array and owns all partial-sum feedback.

---
 rtl/gemm2x2_k_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_gemm2x2_k_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm2x2_k_sequencer.sv
// rtl/gemm2x2_k_sequencer.sv - K-slice sequencer that computes one 2x2 GEMM tile on mac_array_2x2
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, k_len          command pulse and number of K-slices (sampled with start)
//   busy, err             high outside IDLE; sticky timeout flag cleared by next start
//   s_valid/s_ready       K-slice stream handshake, s_a0/s_a1 = A[0..1][k], s_b0/s_b1 = B[k][0..1]
//   mac_in_valid, mac_*   issue strobe, operands and accumulator inputs to the MAC array
//   mac_out_valid, mac_y* MAC array results
//   res_valid/res_ready   finished-tile handshake, res_y* = tile
module gemm2x2_k_sequencer #(
  parameter int KW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 err,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [7:0]    s_a0,
  input  logic signed [7:0]    s_a1,
  input  logic signed [7:0]    s_b0,
  input  logic signed [7:0]    s_b1,
  output logic                 mac_in_valid,
  output logic signed [7:0]    mac_a0,
  output logic signed [7:0]    mac_a1,
  output logic signed [7:0]    mac_b0,
  output logic signed [7:0]    mac_b1,
  output logic signed [31:0]   mac_acc00,
  output logic signed [31:0]   mac_acc01,
  output logic signed [31:0]   mac_acc10,
  output logic signed [31:0]   mac_acc11,
  input  logic                 mac_out_valid,
  input  logic signed [31:0]   mac_y00,
  input  logic signed [31:0]   mac_y01,
  input  logic signed [31:0]   mac_y10,
  input  logic signed [31:0]   mac_y11,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [31:0]   res_y00,
  output logic signed [31:0]   res_y01,
  output logic signed [31:0]   res_y10,
  output logic signed [31:0]   res_y11
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  logic signed [31:0] p00, p01, p10, p11;
  logic [KW-1:0]      cnt;
  logic [KW-1:0]      k_lat;
  logic [TW-1:0]      tcnt;
  logic [KW-1:0]      cnt_next;

  assign cnt_next = cnt + KW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      err          <= 1'b0;
      s_ready      <= 1'b0;
      mac_in_valid <= 1'b0;
      mac_a0       <= '0;
      mac_a1       <= '0;
      mac_b0       <= '0;
      mac_b1       <= '0;
      mac_acc00    <= '0;
      mac_acc01    <= '0;
      mac_acc10    <= '0;
      mac_acc11    <= '0;
      res_valid    <= 1'b0;
      res_y00      <= '0;
      res_y01      <= '0;
      res_y10      <= '0;
      res_y11      <= '0;
      p00          <= '0;
      p01          <= '0;
      p10          <= '0;
      p11          <= '0;
      cnt          <= '0;
      k_lat        <= '0;
      tcnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            p00   <= '0;
            p01   <= '0;
            p10   <= '0;
            p11   <= '0;
            k_lat <= k_len;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            if (k_len == '0) begin
              // Empty reduction: the tile is all zero and no slice is issued.
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_y00   <= '0;
              res_y01   <= '0;
              res_y10   <= '0;
              res_y11   <= '0;
            end else begin
              state   <= S_LOAD;
              s_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (s_valid) begin
            mac_a0       <= s_a0;
            mac_a1       <= s_a1;
            mac_b0       <= s_b0;
            mac_b1       <= s_b1;
            mac_acc00    <= p00;
            mac_acc01    <= p01;
            mac_acc10    <= p10;
            mac_acc11    <= p11;
            s_ready      <= 1'b0;
            mac_in_valid <= 1'b1;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          mac_in_valid <= 1'b0;
          tcnt         <= '0;
          state        <= S_WAIT;
        end

        S_WAIT: begin
          if (mac_out_valid) begin
            p00 <= mac_y00;
            p01 <= mac_y01;
            p10 <= mac_y10;
            p11 <= mac_y11;
            cnt <= cnt_next;
            if (cnt_next == k_lat) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_y00   <= mac_y00;
              res_y01   <= mac_y01;
              res_y10   <= mac_y10;
              res_y11   <= mac_y11;
            end else begin
              state   <= S_LOAD;
              s_ready <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // tcnt==TIMEOUT-1 marks the last allowed WAIT cycle; abort without a result.
            err   <= 1'b1;
            busy  <= 1'b0;
            p00   <= '0;
            p01   <= '0;
            p10   <= '0;
            p11   <= '0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gemm2x2_k_sequencer.sv
// tb/tb_gemm2x2_k_sequencer.sv - directed bench for gemm2x2_k_sequencer with a behavioural 2x2 MAC array
module tb_gemm2x2_k_sequencer;

  localparam int MAC_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [7:0] k_len;
  logic busy, err;
  logic s_valid, s_ready;
  logic signed [7:0] s_a0, s_a1, s_b0, s_b1;
  logic mac_in_valid;
  logic signed [7:0] mac_a0, mac_a1, mac_b0, mac_b1;
  logic signed [31:0] mac_acc00, mac_acc01, mac_acc10, mac_acc11;
  logic mac_out_valid;
  logic signed [31:0] mac_y00, mac_y01, mac_y10, mac_y11;
  logic res_valid, res_ready;
  logic signed [31:0] res_y00, res_y01, res_y10, res_y11;

  logic mac_dead;
  logic stray_ov;
  logic mv, mpend;
  int   mcnt;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  logic signed [31:0] last_acc00, last_acc01, last_acc10, last_acc11;

  always #5 clk = ~clk;

  gemm2x2_k_sequencer #(.KW(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .busy(busy), .err(err),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a0(s_a0), .s_a1(s_a1), .s_b0(s_b0), .s_b1(s_b1),
    .mac_in_valid(mac_in_valid),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_b0(mac_b0), .mac_b1(mac_b1),
    .mac_acc00(mac_acc00), .mac_acc01(mac_acc01), .mac_acc10(mac_acc10), .mac_acc11(mac_acc11),
    .mac_out_valid(mac_out_valid),
    .mac_y00(mac_y00), .mac_y01(mac_y01), .mac_y10(mac_y10), .mac_y11(mac_y11),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y00(res_y00), .res_y01(res_y01), .res_y10(res_y10), .res_y11(res_y11)
  );

  // Behavioural MAC array: y = acc + outer product of (a0,a1) and (b0,b1), MAC_LAT cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv      <= 1'b0;
      mpend   <= 1'b0;
      mcnt    <= 0;
      mac_y00 <= '0;
      mac_y01 <= '0;
      mac_y10 <= '0;
      mac_y11 <= '0;
    end else begin
      mv <= 1'b0;
      if (mac_in_valid && !mac_dead) begin
        mac_y00 <= mac_acc00 + mac_a0 * mac_b0;
        mac_y01 <= mac_acc01 + mac_a0 * mac_b1;
        mac_y10 <= mac_acc10 + mac_a1 * mac_b0;
        mac_y11 <= mac_acc11 + mac_a1 * mac_b1;
        mpend   <= 1'b1;
        mcnt    <= MAC_LAT - 1;
      end else if (mpend) begin
        if (mcnt == 0) begin
          mv    <= 1'b1;
          mpend <= 1'b0;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  assign mac_out_valid = mv | stray_ov;

  always @(posedge clk) begin
    if (mac_in_valid) begin
      issue_cnt  <= issue_cnt + 1;
      last_acc00 <= mac_acc00;
      last_acc01 <= mac_acc01;
      last_acc10 <= mac_acc10;
      last_acc11 <= mac_acc11;
    end
  end

  typedef struct {
    int k;
    int s0[4];
    int s1[4];
    int gap;
    int rdelay;
    int e[4];
    int acc[4];
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_cmd(input int k);
    start = 1'b1;
    k_len = 8'(k);
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clear", err, 0);
  endtask

  task automatic feed(input int a0, input int a1, input int b0, input int b1, input int gap);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_a0 = 8'(a0);
    s_a1 = 8'(a1);
    s_b0 = 8'(b0);
    s_b1 = 8'(b1);
    s_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    check("slice_accept", ok, 1);
    check("issue_pulse", mac_in_valid, 1);
    check("issue_a0", mac_a0, a0);
    check("issue_b1", mac_b1, b1);
  endtask

  task automatic collect(input int e00, input int e01, input int e10, input int e11, input int rdelay);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (res_valid) ok = 1'b1;
      else tick();
    end
    check("res_valid_seen", ok, 1);
    repeat (rdelay) tick();
    check("res_hold_valid", res_valid, 1);
    check("res_y00", res_y00, e00);
    check("res_y01", res_y01, e01);
    check("res_y10", res_y10, e10);
    check("res_y11", res_y11, e11);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_drop", res_valid, 0);
    check("busy_fall", busy, 0);
  endtask

  task automatic run_gemm(input vec_t v);
    int base;
    base = issue_cnt;
    start_cmd(v.k);
    if (v.k == 0) check("k0_res_next_cycle", res_valid, 1);
    else          check("load_s_ready", s_ready, 1);
    if (v.k >= 1) feed(v.s0[0], v.s0[1], v.s0[2], v.s0[3], v.gap);
    if (v.k >= 2) feed(v.s1[0], v.s1[1], v.s1[2], v.s1[3], v.gap);
    collect(v.e[0], v.e[1], v.e[2], v.e[3], v.rdelay);
    check("issue_count", issue_cnt - base, v.k);
    if (v.k == 2) begin
      check("acc2_00", last_acc00, v.acc[0]);
      check("acc2_01", last_acc01, v.acc[1]);
      check("acc2_10", last_acc10, v.acc[2]);
      check("acc2_11", last_acc11, v.acc[3]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;

    vecs[0] = '{k: 2, s0: '{1, 3, 5, 6}, s1: '{2, 4, 7, 8}, gap: 0, rdelay: 0,
                e: '{19, 22, 43, 50}, acc: '{5, 6, 15, 18}};
    vecs[1] = '{k: 1, s0: '{1, 3, 5, 6}, s1: '{0, 0, 0, 0}, gap: 0, rdelay: 0,
                e: '{5, 6, 15, 18}, acc: '{0, 0, 0, 0}};
    vecs[2] = '{k: 0, s0: '{0, 0, 0, 0}, s1: '{0, 0, 0, 0}, gap: 0, rdelay: 0,
                e: '{0, 0, 0, 0}, acc: '{0, 0, 0, 0}};
    vecs[3] = '{k: 2, s0: '{1, 3, 5, 6}, s1: '{2, 4, 7, 8}, gap: 3, rdelay: 5,
                e: '{19, 22, 43, 50}, acc: '{5, 6, 15, 18}};
    vecs[4] = '{k: 2, s0: '{-3, 2, 4, -5}, s1: '{7, -1, -2, 6}, gap: 1, rdelay: 2,
                e: '{-26, 57, 10, -16}, acc: '{-12, 15, 8, -10}};
    vecs[5] = '{k: 2, s0: '{-128, 127, -128, 127}, s1: '{-128, -128, -128, -128}, gap: 0, rdelay: 1,
                e: '{32768, 128, 128, 32513}, acc: '{16384, -16256, -16256, 16129}};

    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    s_valid = 1'b0;
    s_a0 = '0; s_a1 = '0; s_b0 = '0; s_b1 = '0;
    res_ready = 1'b0;
    mac_dead = 1'b0;
    stray_ov = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_mac_in_valid", mac_in_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_y00", res_y00, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_gemm(vecs[i]);

    // Timeout: MAC never answers.
    mac_dead = 1'b1;
    start_cmd(1);
    feed(1, 3, 5, 6, 0);
    repeat (64) tick();
    check("to_busy_before", busy, 1);
    check("to_err_before", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_no_result", res_valid, 0);
    repeat (3) tick();
    check("to_err_sticky", err, 1);
    mac_dead = 1'b0;
    run_gemm(vecs[1]);

    // Stray mac_out_valid in LOAD and start in WAIT are both ignored.
    base = issue_cnt;
    start_cmd(2);
    stray_ov = 1'b1;
    tick();
    stray_ov = 1'b0;
    check("stray_ov_still_load", s_ready, 1);
    feed(1, 3, 5, 6, 0);
    tick();
    start = 1'b1;
    k_len = 8'd5;
    tick();
    start = 1'b0;
    check("stray_start_busy", busy, 1);
    check("stray_start_no_load", s_ready, 0);
    feed(2, 4, 7, 8, 0);
    collect(19, 22, 43, 50, 0);
    check("stray_issue_count", issue_cnt - base, 2);
    check("stray_acc2_11", last_acc11, 18);

    // Reset during WAIT of slice 1.
    start_cmd(2);
    feed(1, 3, 5, 6, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mac_a0", mac_a0, 0);
    check("mid_rst_res_y00", res_y00, 0);
    check("mid_rst_mac_in_valid", mac_in_valid, 0);
    check("mid_rst_s_ready", s_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_gemm(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
